// File: rtl/carregador_pkg.sv
// Shared types for the SAP-1 boot loader: FSM state codes, fault codes and depth helper.
package carregador_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN    = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] CSUM   = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;
  localparam logic [2:0] FAULT  = 3'd6;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_LEN     = 2'b01,
    ERR_CSUM    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/contador_watchdog.sv
// Run-time watchdog: 16-bit counter with clear/enable, flags expiry at TIMEOUT_CYCLES-1.
module contador_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_reg;

  assign expired = (count_reg == 16'(TIMEOUT_CYCLES - 1));

  // Parks at the expiry value so a stalled enable can never wrap back to zero.
  always_ff @(posedge clock) begin
    if (reset || clear)
      count_reg <= '0;
    else if (enable && !expired)
      count_reg <= count_reg + 1'b1;
  end

endmodule

// File: rtl/carregador_programa.sv
// SAP-1 boot sequencer: streams a program into RAM, releases the CPU, watches for HLT.
// Optional checksum byte after the data is enabled by defining CARREGADOR_CHECKSUM_EN.
module carregador_programa
  import carregador_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              cpu_halt,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              ram_we_reg, ram_we_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
  logic              done_reg, done_next;
  err_t              error_reg, error_next;
  logic              in_ready_reg, busy_reg, cpu_reset_reg;
  logic              transfer, wd_expired;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg, sum_next, csum_total;
  assign csum_total = sum_reg + in_data;
`endif

  assign transfer  = in_valid & in_ready_reg;
  assign in_ready  = in_ready_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign cpu_reset = cpu_reset_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;

  contador_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_reg != RUN),
    .enable  (state_reg == RUN),
    .expired (wd_expired)
  );

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    count_next     = count_reg;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    done_next      = done_reg;
    error_next     = error_reg;
`ifdef CARREGADOR_CHECKSUM_EN
    sum_next       = sum_reg;
`endif
    case (state_reg)
      IDLE, HALTED, FAULT: begin
        if (start) begin
          state_next = LEN;
          addr_next  = '0;
          done_next  = 1'b0;
          error_next = ERR_NONE;
        end
      end
      LEN: begin
        if (transfer) begin
          // A zero length byte stands for a full RAM image.
          if (int'(in_data) > DEPTH) begin
            state_next = FAULT;
            error_next = ERR_LEN;
          end else begin
            state_next = DATA;
            count_next = (in_data == '0) ? DEPTH_CNT : (ADDR_W + 1)'(in_data);
          end
`ifdef CARREGADOR_CHECKSUM_EN
          sum_next = in_data;
`endif
        end
      end
      DATA: begin
        if (transfer) begin
          ram_we_next    = 1'b1;
          ram_addr_next  = addr_reg;
          ram_wdata_next = in_data;
          addr_next      = addr_reg + 1'b1;
          count_next     = count_reg - 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
          sum_next = sum_reg + in_data;
          if (count_reg == ONE_CNT)
            state_next = CSUM;
`else
          if (count_reg == ONE_CNT)
            state_next = RUN;
`endif
        end
      end
`ifdef CARREGADOR_CHECKSUM_EN
      CSUM: begin
        if (transfer) begin
          if (csum_total == '0) begin
            state_next = RUN;
          end else begin
            state_next = FAULT;
            error_next = ERR_CSUM;
          end
        end
      end
`endif
      RUN: begin
        // Halt takes priority over a watchdog expiry in the same cycle.
        if (cpu_halt) begin
          state_next = HALTED;
          done_next  = 1'b1;
        end else if (wd_expired) begin
          state_next = FAULT;
          error_next = ERR_TIMEOUT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      count_reg     <= '0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      done_reg      <= 1'b0;
      error_reg     <= ERR_NONE;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      cpu_reset_reg <= 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
      sum_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      count_reg     <= count_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
      // Status outputs are decoded from the next state so they line up with state_reg.
      in_ready_reg  <= (state_next == LEN) || (state_next == DATA) || (state_next == CSUM);
      busy_reg      <= (state_next == LEN) || (state_next == DATA) ||
                       (state_next == CSUM) || (state_next == RUN);
      cpu_reset_reg <= !((state_next == RUN) || (state_next == HALTED));
`ifdef CARREGADOR_CHECKSUM_EN
      sum_reg       <= sum_next;
`endif
    end
  end

endmodule

// File: tb/tb_carregador_programa.sv
// Scoreboard bench for carregador_programa: expected RAM writes queued by the driver, checked by a monitor.
module tb_carregador_programa;

  localparam int TIMEOUT = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_halt = 1'b0;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic [1:0] error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    int         at;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] prog [16];

  carregador_programa #(.ADDR_W(4), .DATA_W(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_halt  (cpu_halt),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // Monitor: every RAM write must match the oldest queued expectation, on the expected cycle.
  always @(negedge clock) begin
    wr_t e;
    if (ram_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_write: got addr=%0h data=%02h, expected no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e.addr || ram_wdata !== e.data || cyc != e.at) begin
          errors++;
          $display("FAIL ram_write: got addr=%0h data=%02h cyc=%0d, expected addr=%0h data=%02h cyc=%0d",
                   ram_addr, ram_wdata, cyc, e.addr, e.data, e.at);
        end else begin
          $display("write addr=%0h data=%02h cyc=%0d ok", ram_addr, ram_wdata, cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the byte was transferred.
  task automatic push_byte(input logic [7:0] b, input bit is_data, input logic [3:0] addr, input int gap);
    int w;
    w = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clock);
    end
    while (in_ready !== 1'b1 && w < 40) begin
      in_valid = 1'b0;
      @(negedge clock);
      w++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got in_ready=%b, expected 1 within 40 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    if (is_data) exp_q.push_back('{addr: addr, data: b, at: cyc + 1});
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_prog(input logic [7:0] len, input int cnt, input int gap_max);
    logic [7:0] sum;
    sum = len;
    push_byte(len, 1'b0, 4'h0, 0);
    for (int i = 0; i < cnt; i++) begin
      push_byte(prog[i], 1'b1, 4'(i), $urandom_range(0, gap_max));
      sum = sum + prog[i];
    end
`ifdef CARREGADOR_CHECKSUM_EN
    push_byte(8'(8'h00 - sum), 1'b0, 4'h0, 0);
`else
    if (sum == 8'h00) $display("note: stream sum is zero");
`endif
  endtask

  task automatic do_start;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic pulse_halt;
    cpu_halt = 1'b1;
    @(negedge clock);
    cpu_halt = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: three-byte program, back-to-back stream, halt after 10 RUN cycles
    do_start();
    chk("t1_ready_len", 32'(in_ready), 32'd1);
    chk("t1_busy_len", 32'(busy), 32'd1);
    prog[0] = 8'hA1; prog[1] = 8'hB2; prog[2] = 8'hC3;
    send_prog(8'h03, 3, 0);
    chk("t1_cpu_reset_run", 32'(cpu_reset), 32'd0);
    chk("t1_ready_run", 32'(in_ready), 32'd0);
    repeat (10) @(negedge clock);
    chk("t1_still_run", 32'(busy), 32'd1);
    pulse_halt();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_busy_halted", 32'(busy), 32'd0);
    chk("t1_cpu_reset_halted", 32'(cpu_reset), 32'd0);

    // 2: N=0 loads the full 16 words, 17th byte refused
    do_start();
    chk("t2_cpu_reset_len", 32'(cpu_reset), 32'd1);
    chk("t2_done_cleared", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) prog[i] = 8'(8'h40 + i);
    send_prog(8'h00, 16, 0);
    chk("t2_ready_after", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    chk("t2_cpu_reset_run", 32'(cpu_reset), 32'd0);
    pulse_halt();
    chk("t2_done", 32'(done), 32'd1);

    // 3: length 0x11 exceeds depth
    do_start();
    push_byte(8'h11, 1'b0, 4'h0, 0);
    chk("t3_error_len", 32'(error), 32'd1);
    chk("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_ready", 32'(in_ready), 32'd0);
    do_start();
    chk("t3_error_cleared", 32'(error), 32'd0);
    chk("t3_busy_restart", 32'(busy), 32'd1);

    // 4: watchdog timeout exactly TIMEOUT edges after RUN entry
    prog[0] = 8'h55;
    send_prog(8'h01, 1, 0);
    repeat (TIMEOUT - 1) @(negedge clock);
    chk("t4_run_before_expiry", 32'(error), 32'd0);
    chk("t4_cpu_reset_before", 32'(cpu_reset), 32'd0);
    @(negedge clock);
    chk("t4_error_timeout", 32'(error), 32'd3);
    chk("t4_cpu_reset_fault", 32'(cpu_reset), 32'd1);
    chk("t4_busy_fault", 32'(busy), 32'd0);
    // variant: halt on the expiry cycle wins
    do_start();
    send_prog(8'h01, 1, 0);
    repeat (TIMEOUT - 1) @(negedge clock);
    pulse_halt();
    chk("t4b_done", 32'(done), 32'd1);
    chk("t4b_error", 32'(error), 32'd0);
    chk("t4b_cpu_reset", 32'(cpu_reset), 32'd0);

    // 5: gappy stream, reset after the 2nd data byte
    do_start();
    push_byte(8'h04, 1'b0, 4'h0, 0);
    push_byte(8'h5A, 1'b1, 4'h0, $urandom_range(0, 2));
    push_byte(8'hA5, 1'b1, 4'h1, $urandom_range(0, 2));
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(negedge clock);
    reset = 1'b0;
    chk("t5_ram_we", 32'(ram_we), 32'd0);
    chk("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("t5_idle_ready", 32'(in_ready), 32'd0);

    // 6: checksum handling
    do_start();
    push_byte(8'h02, 1'b0, 4'h0, 0);
    push_byte(8'h10, 1'b1, 4'h0, 0);
    push_byte(8'h20, 1'b1, 4'h1, 0);
`ifdef CARREGADOR_CHECKSUM_EN
    push_byte(8'hCE, 1'b0, 4'h0, 0);
    chk("t6_good_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("t6_good_error", 32'(error), 32'd0);
    pulse_halt();
    do_start();
    push_byte(8'h02, 1'b0, 4'h0, 0);
    push_byte(8'h10, 1'b1, 4'h0, 0);
    push_byte(8'h20, 1'b1, 4'h1, 0);
    push_byte(8'hCF, 1'b0, 4'h0, 0);
    chk("t6_bad_error", 32'(error), 32'd2);
    chk("t6_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t6_bad_busy", 32'(busy), 32'd0);
`else
    chk("t6_run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("t6_run_busy", 32'(busy), 32'd1);
    chk("t6_run_error", 32'(error), 32'd0);
`endif

    repeat (3) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
